sha1_pad_sequencer: RTL and testbench
=====================================

SHA1_PAD_SEQUENCER -- requirements
Module: sha1_pad_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-002 SHALL have ports: start  in  1  begin hash job (pulse); message_size  in  32  message length in bytes; base_addr  in  16  byte address of message word 0.
REQ-003 SHALL have ports: hold  in  1  suppress word issue this cycle; block_done  in  1  compute core finished current block (pulse).
REQ-004 SHALL have ports: mem_addr  out  16  memory byte address; mem_rd  out  1  memory read strobe (read data valid next cycle).
REQ-005 SHALL have ports: sel_port, sel_zero, sel_upper, sel_lower, sel_concat  out  1 each  one-hot word-source select for the read/pad datapath.
REQ-006 SHALL have ports: word_valid  out  1  selects valid this cycle; word_idx  out  4  word index within block (0-15).
REQ-007 SHALL have ports: padding_length  out  32  padded length in bytes; busy  out  1  job in progress; done  out  1  one-cycle completion pulse.

Function
REQ-008 SHALL implement states IDLE, CALC, LOAD, WAIT, DONE.
REQ-009 IDLE: start=1 SHALL capture message_size and base_addr, go to CALC; start while not IDLE SHALL be ignored.
REQ-010 CALC (one cycle): SHALL compute nblk = ((size+8)>>6)+1 and padding_length = nblk*64 (32-bit, mod 2^32), go to LOAD with block and word counters cleared.
REQ-011 padding_length SHALL hold its value until the next CALC.
REQ-012 LOAD: an issue SHALL occur in a cycle iff hold=0 and fewer than 16 words of the current block have been issued.
REQ-013 Issued word global index g = 16*block+word; byte offset b = 4*g.
REQ-014 Source per issued word: b+4 <= size -> port; else b == 4*floor(size/4) -> concat; else g == 16*nblk-2 -> upper; else g == 16*nblk-1 -> lower; else zero.
REQ-015 On issue: mem_addr = base_addr + b (mod 2^16); mem_rd=1 for port words and for concat words when size%4 != 0; otherwise mem_rd=0, mem_addr unchanged.
REQ-016 Exactly one sel_* SHALL be high, with word_valid=1 and word_idx=g%16, in the cycle after the issue (aligned with memory read data); all sel_* and word_valid SHALL be 0 in cycles not following an issue.
REQ-017 hold=1 SHALL only suppress issue that cycle; a word issued in the previous cycle SHALL still present word_valid next cycle.
REQ-018 After 16th issue of a block SHALL go to WAIT.
REQ-019 WAIT: block_done=1 SHALL increment block; if block < nblk go to LOAD, else go to DONE.
REQ-020 block_done outside WAIT SHALL be ignored; block_done in the same cycle the 16th word is issued SHALL be ignored.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE.
REQ-022 busy SHALL be 1 in CALC, LOAD, WAIT, DONE and 0 in IDLE.
REQ-023 mem_rd SHALL never be asserted outside LOAD.

Reset
REQ-024 reset=1 SHALL asynchronously force IDLE; clear counters; set mem_addr=0, mem_rd=0, all sel_*=0, word_valid=0, word_idx=0, padding_length=0, busy=0, done=0.
REQ-025 reset mid-job SHALL abandon the job with no further mem_rd, word_valid, or done; the next start SHALL behave as from power-up.

Verification
REQ-026 size=0, base=0x0100 -> padding_length=64; word 0 concat with mem_rd=0; words 1-13 zero; word 14 upper; word 15 lower; no mem_rd; done after one block_done.
REQ-027 size=3, base=0x0000 -> word 0 concat with mem_rd=1 at mem_addr 0x0000; words 1-13 zero; 14 upper; 15 lower.
REQ-028 size=55 -> padding_length=64, words 0-12 port, word 13 concat (mem_rd at base+52), 14/15 upper/lower. size=56 -> padding_length=128; block 0: words 0-13 port, word 14 concat with mem_rd=0; block 1: words 0-13 zero, 14 upper, 15 lower.
REQ-029 size=64, hold=1 for 3 cycles after word 5 issued -> word 5 still valid next cycle; no issue or word_valid during the gap; remaining words resume in order; WAIT entered only after 16 issues.
REQ-030 reset pulsed during block-1 LOAD of a 2-block job -> all outputs 0 immediately; no done; new start with size=0 completes normally.

Source files
------------

// File: rtl/sha1_pad_sequencer.sv
// Address/select sequencer for SHA-1 message padding: walks each 512-bit block word by word,
// issuing memory reads for message words and steering the pad datapath for the rest.
module sha1_pad_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] message_size,
    input  logic [15:0] base_addr,
    input  logic        hold,
    input  logic        block_done,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        sel_port,
    output logic        sel_zero,
    output logic        sel_upper,
    output logic        sel_lower,
    output logic        sel_concat,
    output logic        word_valid,
    output logic [3:0]  word_idx,
    output logic [31:0] padding_length,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {StIdle, StCalc, StLoad, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] size_q, size_d;
    logic [15:0] base_q, base_d;
    logic [31:0] nblk_q, nblk_d;
    logic [31:0] pad_q, pad_d;
    logic [31:0] block_q, block_d;
    logic [3:0]  word_q, word_d;
    logic [15:0] addr_q, addr_d;
    logic [4:0]  sel_q, sel_d;
    logic        valid_q, valid_d;
    logic [3:0]  idx_q, idx_d;

    logic        issue;
    logic [35:0] g;
    logic [37:0] b;
    logic        is_port, is_concat, is_upper, is_lower, need_rd;
    logic [4:0]  src_sel;
    logic [15:0] rd_addr;

    // Global word index and byte offset kept wide so comparisons against size never wrap.
    assign g         = {block_q, word_q};
    assign b         = {g, 2'b00};
    assign is_port   = (b + 38'd4) <= {6'd0, size_q};
    assign is_concat = b == {6'd0, size_q[31:2], 2'b00};
    assign is_upper  = g == ({nblk_q, 4'b0000} - 36'd2);
    assign is_lower  = g == ({nblk_q, 4'b0000} - 36'd1);
    assign need_rd   = is_port | (is_concat & (|size_q[1:0]));

    // sel bit order: {port, zero, upper, lower, concat}
    always_comb begin
        src_sel = 5'b01000;
        if (is_port) begin
            src_sel = 5'b10000;
        end else if (is_concat) begin
            src_sel = 5'b00001;
        end else if (is_upper) begin
            src_sel = 5'b00100;
        end else if (is_lower) begin
            src_sel = 5'b00010;
        end
    end

    assign issue    = (state_q == StLoad) && !hold;
    assign rd_addr  = base_q + b[15:0];
    assign mem_rd   = issue && need_rd;
    assign mem_addr = mem_rd ? rd_addr : addr_q;

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        base_d  = base_q;
        nblk_d  = nblk_q;
        pad_d   = pad_q;
        block_d = block_q;
        word_d  = word_q;
        addr_d  = addr_q;
        sel_d   = 5'b00000;
        valid_d = 1'b0;
        idx_d   = idx_q;

        if (mem_rd) begin
            addr_d = rd_addr;
        end
        // Selects trail the issue by one cycle to line up with read data.
        if (issue) begin
            valid_d = 1'b1;
            idx_d   = word_q;
            sel_d   = src_sel;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    size_d  = message_size;
                    base_d  = base_addr;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                nblk_d  = ((size_q + 32'd8) >> 6) + 32'd1;
                pad_d   = {nblk_d[25:0], 6'd0};
                block_d = 32'd0;
                word_d  = 4'd0;
                state_d = StLoad;
            end
            StLoad: begin
                if (issue) begin
                    word_d = word_q + 4'd1;
                    if (word_q == 4'd15) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (block_done) begin
                    block_d = block_q + 32'd1;
                    word_d  = 4'd0;
                    state_d = (block_d < nblk_q) ? StLoad : StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            size_q  <= 32'd0;
            base_q  <= 16'd0;
            nblk_q  <= 32'd0;
            pad_q   <= 32'd0;
            block_q <= 32'd0;
            word_q  <= 4'd0;
            addr_q  <= 16'd0;
            sel_q   <= 5'b00000;
            valid_q <= 1'b0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            base_q  <= base_d;
            nblk_q  <= nblk_d;
            pad_q   <= pad_d;
            block_q <= block_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign sel_port       = sel_q[4];
    assign sel_zero       = sel_q[3];
    assign sel_upper      = sel_q[2];
    assign sel_lower      = sel_q[1];
    assign sel_concat     = sel_q[0];
    assign word_valid     = valid_q;
    assign word_idx       = idx_q;
    assign padding_length = pad_q;
    assign busy           = state_q != StIdle;
    assign done           = state_q == StDone;

endmodule

// File: tb/tb_sha1_pad_sequencer.sv
// Directed bench for sha1_pad_sequencer: full jobs of several sizes, hold gaps,
// stray start/block_done pulses and a mid-job reset.
module tb_sha1_pad_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] message_size = 32'd0;
    logic [15:0] base_addr = 16'd0;
    logic        hold = 1'b0;
    logic        block_done = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        sel_port, sel_zero, sel_upper, sel_lower, sel_concat;
    logic        word_valid;
    logic [3:0]  word_idx;
    logic [31:0] padding_length;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    sha1_pad_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .message_size  (message_size),
        .base_addr     (base_addr),
        .hold          (hold),
        .block_done    (block_done),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .sel_port      (sel_port),
        .sel_zero      (sel_zero),
        .sel_upper     (sel_upper),
        .sel_lower     (sel_lower),
        .sel_concat    (sel_concat),
        .word_valid    (word_valid),
        .word_idx      (word_idx),
        .padding_length(padding_length),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sel_now();
        return {27'd0, sel_port, sel_zero, sel_upper, sel_lower, sel_concat};
    endfunction

    // Expected select, order {port, zero, upper, lower, concat}
    function automatic logic [31:0] exp_sel(input int unsigned size, input int unsigned g,
                                            input int unsigned nblk);
        longint unsigned bo;
        bo = 4 * longint'(g);
        if (bo + 4 <= longint'(size)) return 32'b10000;
        if (bo == longint'((size / 4) * 4)) return 32'b00001;
        if (g == 16 * nblk - 2) return 32'b00100;
        if (g == 16 * nblk - 1) return 32'b00010;
        return 32'b01000;
    endfunction

    function automatic bit exp_rd(input int unsigned size, input int unsigned g,
                                  input int unsigned nblk);
        logic [31:0] s;
        s = exp_sel(size, g, nblk);
        return (s == 32'b10000) || (s == 32'b00001 && (size % 4) != 0);
    endfunction

    // Starts at a negedge with the DUT in LOAD of block blk; ends at a negedge
    // in LOAD of the next block, or in IDLE after the done pulse.
    task automatic run_block(input int unsigned size, input int unsigned base,
                             input int unsigned blk, input int unsigned nblk,
                             input int hold_after, input int hold_cycles,
                             input logic [31:0] exp_pad);
        int w = 0;
        bit prev = 0;
        int unsigned pg = 0;
        int hl = 0;
        int unsigned g;
        while (w < 16 || prev) begin
            block_done = 1'b0;
            hold = 1'b0;
            check_eq("word_valid", {31'd0, word_valid}, {31'd0, prev});
            if (prev) begin
                check_eq($sformatf("sel g=%0d", pg), sel_now(), exp_sel(size, pg, nblk));
                check_eq("word_idx", {28'd0, word_idx}, pg % 16);
            end else begin
                check_eq("sel_idle", sel_now(), 32'd0);
            end
            prev = 0;
            if (w < 16) begin
                hold = (hl > 0);
                // stray block_done alongside the 16th issue must be ignored
                if (w == 15 && !hold) block_done = 1'b1;
                #1;
                if (hold) begin
                    check_eq("rd_held", {31'd0, mem_rd}, 32'd0);
                    hl--;
                end else begin
                    g = 16 * blk + w;
                    check_eq($sformatf("rd g=%0d", g), {31'd0, mem_rd},
                             {31'd0, exp_rd(size, g, nblk)});
                    if (exp_rd(size, g, nblk))
                        check_eq($sformatf("addr g=%0d", g), {16'd0, mem_addr},
                                 (base + 4 * g) & 32'hFFFF);
                    pg = g;
                    prev = 1;
                    if (w == hold_after) hl = hold_cycles;
                    w++;
                end
            end
            @(negedge clk);
        end
        // WAIT: quiet outputs, start ignored
        check_eq("wait_valid", {31'd0, word_valid}, 32'd0);
        check_eq("wait_rd", {31'd0, mem_rd}, 32'd0);
        check_eq("wait_busy", {31'd0, busy}, 32'd1);
        check_eq("wait_done", {31'd0, done}, 32'd0);
        start = 1'b1;
        message_size = 32'hFFFF_FFFF;
        base_addr = 16'hABCD;
        @(negedge clk);
        start = 1'b0;
        check_eq("pad_after_start", padding_length, exp_pad);
        check_eq("wait_busy2", {31'd0, busy}, 32'd1);
        check_eq("wait_valid2", {31'd0, word_valid}, 32'd0);
        block_done = 1'b1;
        @(negedge clk);
        block_done = 1'b0;
        if (blk + 1 == nblk) begin
            check_eq("done_pulse", {31'd0, done}, 32'd1);
            check_eq("done_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
            check_eq("done_cleared", {31'd0, done}, 32'd0);
            check_eq("idle_busy", {31'd0, busy}, 32'd0);
        end else begin
            check_eq("no_done", {31'd0, done}, 32'd0);
        end
    endtask

    // Starts the job and leaves the DUT at a negedge in LOAD of block 0.
    task automatic begin_job(input int unsigned size, input int unsigned base,
                             input logic [31:0] exp_pad);
        @(negedge clk);
        start = 1'b1;
        message_size = size;
        base_addr = base[15:0];
        @(negedge clk);
        start = 1'b0;
        message_size = 32'd0;
        base_addr = 16'd0;
        check_eq("calc_busy", {31'd0, busy}, 32'd1);
        check_eq("calc_rd", {31'd0, mem_rd}, 32'd0);
        check_eq("calc_valid", {31'd0, word_valid}, 32'd0);
        @(negedge clk);
        check_eq($sformatf("pad size=%0d", size), padding_length, exp_pad);
    endtask

    task automatic run_job(input int unsigned size, input int unsigned base,
                           input logic [31:0] exp_pad, input int hold_after,
                           input int hold_cycles);
        int unsigned nblk;
        nblk = exp_pad / 64;
        begin_job(size, base, exp_pad);
        for (int unsigned bk = 0; bk < nblk; bk++)
            run_block(size, base, bk, nblk, (bk == 0) ? hold_after : 99, hold_cycles, exp_pad);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
        check_eq({tag, "_rd"}, {31'd0, mem_rd}, 32'd0);
        check_eq({tag, "_sel"}, sel_now(), 32'd0);
        check_eq({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
        check_eq({tag, "_idx"}, {28'd0, word_idx}, 32'd0);
        check_eq({tag, "_pad"}, padding_length, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #1;
        check_all_zero("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_job(0, 32'h0100, 32'd64, 99, 0);
        run_job(3, 32'h0000, 32'd64, 99, 0);
        run_job(55, 32'h1000, 32'd64, 99, 0);
        run_job(56, 32'h2000, 32'd128, 99, 0);
        // hold gap after word 5, address wraps past 0xFFFF
        run_job(64, 32'hFFF0, 32'd128, 5, 3);

        // reset in the middle of block 1 of a two-block job
        begin_job(64, 32'h0000, 32'd128);
        run_block(64, 32'h0000, 0, 2, 99, 0, 32'd128);
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_valid", {31'd0, word_valid}, 32'd0);
            check_eq("post_rst_rd", {31'd0, mem_rd}, 32'd0);
            check_eq("post_rst_done", {31'd0, done}, 32'd0);
            check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        run_job(0, 32'h0040, 32'd64, 99, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
